// File: rtl/atm_light_pixel_normalizer.sv
// Scales RGB pixels by latched per-channel reciprocals 1/A through a 3-stage valid/ready pipeline.
// Define ATM_NORM_ROUND_EN to round half up before the final shift instead of truncating.
module atm_light_pixel_normalizer #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned RECIP_W   = 10,
  parameter int unsigned FRAC_BITS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              recip_load,
  input  logic [RECIP_W-1:0] recip_r,
  input  logic [RECIP_W-1:0] recip_g,
  input  logic [RECIP_W-1:0] recip_b,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_r,
  input  logic [DATA_W-1:0] in_g,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_r,
  output logic [DATA_W-1:0] out_g,
  output logic [DATA_W-1:0] out_b,
  output logic              out_last,
  output logic              busy
);

  localparam int unsigned EFF_W  = RECIP_W + 1;
  localparam int unsigned PROD_W = DATA_W + RECIP_W + 1;
  localparam int unsigned SUM_W  = PROD_W + 1;
  localparam logic [EFF_W-1:0]  UNITY   = EFF_W'(1) << FRAC_BITS;
  localparam logic [SUM_W-1:0]  MAX_OUT = SUM_W'({DATA_W{1'b1}});
`ifdef ATM_NORM_ROUND_EN
  localparam logic [SUM_W-1:0]  HALF    = SUM_W'(1) << (FRAC_BITS - 1);
`endif

  logic [RECIP_W-1:0] recip_r_q, recip_g_q, recip_b_q;
  logic [RECIP_W-1:0] shadow_r_q, shadow_g_q, shadow_b_q;
  logic               pending_q;

  logic               v1_q, v2_q;
  logic [DATA_W-1:0]  s1_r_q, s1_g_q, s1_b_q;
  logic [EFF_W-1:0]   s1_er_q, s1_eg_q, s1_eb_q;
  logic               s1_last_q, s2_last_q;
  logic [PROD_W-1:0]  s2_r_q, s2_g_q, s2_b_q;

  logic stall, empty, accept;

  // Code 0 stands for unity so an unprogrammed block passes pixels through.
  function automatic logic [EFF_W-1:0] eff_of(input logic [RECIP_W-1:0] code);
    return (code == '0) ? UNITY : {1'b0, code};
  endfunction

  function automatic logic [DATA_W-1:0] scale(input logic [PROD_W-1:0] prod);
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] shifted;
`ifdef ATM_NORM_ROUND_EN
    sum = {1'b0, prod} + HALF;
`else
    sum = {1'b0, prod};
`endif
    shifted = sum >> FRAC_BITS;
    return (shifted > MAX_OUT) ? MAX_OUT[DATA_W-1:0] : shifted[DATA_W-1:0];
  endfunction

  always_comb begin
    stall    = out_valid & ~out_ready;
    empty    = ~(v1_q | v2_q | out_valid);
    // A load request in the same cycle blocks input so the load always wins.
    in_ready = ~stall & ~pending_q & ~recip_load;
    accept   = in_valid & in_ready;
    busy     = pending_q | ~empty;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      recip_r_q  <= '0;
      recip_g_q  <= '0;
      recip_b_q  <= '0;
      shadow_r_q <= '0;
      shadow_g_q <= '0;
      shadow_b_q <= '0;
      pending_q  <= 1'b0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      out_valid  <= 1'b0;
      s1_r_q     <= '0;
      s1_g_q     <= '0;
      s1_b_q     <= '0;
      s1_er_q    <= '0;
      s1_eg_q    <= '0;
      s1_eb_q    <= '0;
      s1_last_q  <= 1'b0;
      s2_r_q     <= '0;
      s2_g_q     <= '0;
      s2_b_q     <= '0;
      s2_last_q  <= 1'b0;
      out_r      <= '0;
      out_g      <= '0;
      out_b      <= '0;
      out_last   <= 1'b0;
    end else begin
      if (recip_load) begin
        if (empty && !pending_q) begin
          recip_r_q <= recip_r;
          recip_g_q <= recip_g;
          recip_b_q <= recip_b;
        end else begin
          shadow_r_q <= recip_r;
          shadow_g_q <= recip_g;
          shadow_b_q <= recip_b;
          pending_q  <= 1'b1;
        end
      end else if (pending_q && empty) begin
        recip_r_q <= shadow_r_q;
        recip_g_q <= shadow_g_q;
        recip_b_q <= shadow_b_q;
        pending_q <= 1'b0;
      end

      if (!stall) begin
        v1_q <= accept;
        if (accept) begin
          s1_r_q    <= in_r;
          s1_g_q    <= in_g;
          s1_b_q    <= in_b;
          s1_last_q <= in_last;
          s1_er_q   <= eff_of(recip_r_q);
          s1_eg_q   <= eff_of(recip_g_q);
          s1_eb_q   <= eff_of(recip_b_q);
        end
        v2_q <= v1_q;
        if (v1_q) begin
          s2_r_q    <= PROD_W'(s1_r_q) * PROD_W'(s1_er_q);
          s2_g_q    <= PROD_W'(s1_g_q) * PROD_W'(s1_eg_q);
          s2_b_q    <= PROD_W'(s1_b_q) * PROD_W'(s1_eb_q);
          s2_last_q <= s1_last_q;
        end
        out_valid <= v2_q;
        if (v2_q) begin
          out_r    <= scale(s2_r_q);
          out_g    <= scale(s2_g_q);
          out_b    <= scale(s2_b_q);
          out_last <= s2_last_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_atm_light_pixel_normalizer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_atm_light_pixel_normalizer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       recip_load;
  logic [9:0] recip_r, recip_g, recip_b;
  logic       in_valid, in_ready, in_last;
  logic [7:0] in_r, in_g, in_b;
  logic       out_valid, out_ready, out_last, busy;
  logic [7:0] out_r, out_g, out_b;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  logic [24:0] exp_q[$];
  int unsigned mr = 0, mg = 0, mb = 0;

  always #5 clk = ~clk;

  atm_light_pixel_normalizer dut (
    .clk(clk), .rst_n(rst_n), .recip_load(recip_load),
    .recip_r(recip_r), .recip_g(recip_g), .recip_b(recip_b),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_last(out_last),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: I/A with A given as a Q0.10 reciprocal code (0 means 1.0), clamped to 8 bits.
  function automatic int unsigned norm(input int unsigned ch, input int unsigned code);
    int unsigned eff, v;
    eff = (code == 0) ? 1024 : code;
    v = ch * eff;
`ifdef ATM_NORM_ROUND_EN
    v = v + 512;
`endif
    v = v / 1024;
    return (v > 255) ? 255 : v;
  endfunction

  // Scoreboard: a pixel uses the most recent load issued before it was accepted.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      mr = 0; mg = 0; mb = 0;
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("out_unexpected", 1, 0);
        end else begin
          logic [24:0] e;
          e = exp_q.pop_front();
          check("out_pixel", {7'd0, out_last, out_r, out_g, out_b}, {7'd0, e});
        end
      end
      if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
      if (recip_load) begin
        mr = recip_r; mg = recip_g; mb = recip_b;
      end
      if (in_valid && in_ready)
        exp_q.push_back({in_last, 8'(norm(in_r, mr)), 8'(norm(in_g, mg)), 8'(norm(in_b, mb))});
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    recip_load = 1'b1; recip_r = r; recip_g = g; recip_b = b;
    tick();
    recip_load = 1'b0;
  endtask

  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic last);
    bit ok;
    ok = 0;
    in_valid = 1'b1; in_r = r; in_g = g; in_b = b; in_last = last;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    if (!ok) check("send_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    bit ok;
    ok = 0;
    lat = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) ok = 1;
    end
    if (!ok) check("wait_out_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (exp_q.size() != 0 || busy); i++) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int lat, sent, base;
    rst_n = 1'b0; recip_load = 1'b0; recip_r = '0; recip_g = '0; recip_b = '0;
    in_valid = 1'b0; in_r = '0; in_g = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_r", out_r, 0);
    check("rst_in_ready", in_ready, 1);
    tick();

    // Unity after reset, 3-cycle latency
    send(8'd200, 8'd100, 8'd50, 1'b1);
    wait_out(lat);
    check("t1_latency", lat, 3);
    check("t1_rgb", {out_r, out_g, out_b}, {8'd200, 8'd100, 8'd50});
    check("t1_last", out_last, 1);
    tick();

    load(10'd146, 10'd146, 10'd146);
    send(8'd7, 8'd14, 8'd255, 1'b0);
    wait_out(lat);
`ifdef ATM_NORM_ROUND_EN
    check("t2_rgb", {out_r, out_g, out_b}, {8'd1, 8'd2, 8'd36});
`else
    check("t2_rgb", {out_r, out_g, out_b}, {8'd0, 8'd1, 8'd36});
`endif
    tick();

    load(10'd256, 10'd256, 10'd256);
    send(8'd2, 8'd3, 8'd255, 1'b0);
    wait_out(lat);
`ifdef ATM_NORM_ROUND_EN
    check("t3_rgb", {out_r, out_g, out_b}, {8'd1, 8'd1, 8'd64});
`else
    check("t3_rgb", {out_r, out_g, out_b}, {8'd0, 8'd0, 8'd63});
`endif
    tick();
    load(10'd0, 10'd0, 10'd0);
    send(8'd255, 8'd255, 8'd255, 1'b1);
    wait_out(lat);
    check("t3_unity", {out_r, out_g, out_b}, {8'd255, 8'd255, 8'd255});
    tick();

    // 20-pixel stream with a downstream stall
    load(10'($urandom_range(1023)), 10'($urandom_range(1023)), 10'($urandom_range(1023)));
    base = n_out;
    sent = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      out_ready = !(cyc >= 5 && cyc <= 9);
      in_valid = (sent < 20);
      in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom);
      in_last = (sent == 19);
      @(negedge clk);
      if (cyc == 7) check("t4_stall_in_ready", in_ready, 0);
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();
    check("t4_sent", sent, 20);
    check("t4_outputs", n_out - base, 20);

    // Load with pixels in flight
    load(10'd0, 10'd0, 10'd0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_r = 8'(40 + i); in_g = 8'(80 + i); in_b = 8'(120 + i); in_last = 1'b0;
      @(negedge clk);
      check("t5_accept", in_ready, 1);
      tick();
    end
    recip_load = 1'b1; recip_r = 10'd205; recip_g = 10'd205; recip_b = 10'd205;
    in_r = 8'd250; in_g = 8'd100; in_b = 8'd5; in_last = 1'b1;
    @(negedge clk);
    check("t5_load_blocks", in_ready, 0);
    tick();
    recip_load = 1'b0;
    @(negedge clk);
    check("t5_pending_ready", in_ready, 0);
    check("t5_pending_busy", busy, 1);
    lat = 0;
    for (int i = 0; i < 20 && !in_ready; i++) begin
      tick();
      @(negedge clk);
      lat++;
    end
    check("t5_ready_returns", in_ready, 1);
    tick();
    in_valid = 1'b0;
    drain();

    // Reset while holding an output
    load(10'd99, 10'd300, 10'd777);
    out_ready = 1'b0;
    in_valid = 1'b1; in_r = 8'd11; in_g = 8'd22; in_b = 8'd33; in_last = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(negedge clk);
      if (!out_valid) tick();
    end
    check("t6_out_held", out_valid, 1);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_out_r", out_r, 0);
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    send(8'd255, 8'd128, 8'd9, 1'b1);
    wait_out(lat);
    check("t6_unity", {out_r, out_g, out_b}, {8'd255, 8'd128, 8'd9});
    tick();

    // Random traffic with occasional loads and backpressure
    for (int cyc = 0; cyc < 400; cyc++) begin
      recip_load = ($urandom_range(19) == 0);
      recip_r = 10'($urandom); recip_g = 10'($urandom); recip_b = 10'($urandom);
      in_valid = ($urandom_range(3) != 0);
      in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom); in_last = 1'($urandom);
      out_ready = ($urandom_range(3) != 0);
      tick();
    end
    recip_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drain();
    check("final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
